// File: rtl/mem_read_port.sv
// mem_read_port: read side of the processor's load-capable data registers.
// A request from the control unit starts one handshaked read on the external
// memory bus. The returned word is captured into a holding register for the datapath.
// A bus timeout keeps a missing responder from hanging the core.
// All state updates happen on the falling clock edge.

module mem_read_port #(
    parameter int DATAWIDTH = 16,
    parameter int ADDRWIDTH = 16,
    parameter int TIMEOUT   = 64,
    parameter int TWIDTH    = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_n_i,
    input  logic [ADDRWIDTH-1:0] addr_in_i,
    output logic [DATAWIDTH-1:0] data_out_o,
    output logic                 done_o,
    output logic                 busy_o,
    output logic                 error_o,
    output logic [ADDRWIDTH-1:0] bus_addr_o,
    output logic                 bus_rd_n_o,
    input  logic [DATAWIDTH-1:0] bus_data_in_i,
    input  logic                 bus_ready_n_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // The last timer value before an abort. When TIMEOUT is 0 the compare is never enabled.
    localparam logic [TWIDTH-1:0] TIMER_LAST = TWIDTH'(TIMEOUT - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);

    state_t                 state_q,   state_d;
    logic                   armed_q,   armed_d;
    logic [TWIDTH-1:0]      timer_q,   timer_d;
    logic [ADDRWIDTH-1:0]   busAddr_q, busAddr_d;
    logic                   busRdN_q,  busRdN_d;
    logic [DATAWIDTH-1:0]   dataOut_q, dataOut_d;
    logic                   done_q,    done_d;
    logic                   busy_q,    busy_d;
    logic                   error_q,   error_d;

    // State register on the falling edge. A low reset wipes everything and aborts any read in flight.
    always_ff @(negedge clk_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            armed_q   <= 1'b1;
            timer_q   <= '0;
            busAddr_q <= '0;
            busRdN_q  <= 1'b1;
            dataOut_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            timer_q   <= timer_d;
            busAddr_q <= busAddr_d;
            busRdN_q  <= busRdN_d;
            dataOut_q <= dataOut_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
        end
    end

    // Next state. A request is accepted only on a fresh low level of start_n.
    // Ready wins over timeout when both land on the same edge.
    always_comb begin
        state_d   = state_q;
        armed_d   = start_n_i ? 1'b1 : armed_q;
        timer_d   = timer_q;
        busAddr_d = busAddr_q;
        busRdN_d  = busRdN_q;
        dataOut_d = dataOut_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        error_d   = error_q;

        unique case (state_q)
            IDLE: begin
                if (!start_n_i && armed_q) begin
                    armed_d   = 1'b0;
                    busAddr_d = addr_in_i;
                    busRdN_d  = 1'b0;
                    busy_d    = 1'b1;
                    error_d   = 1'b0;
                    timer_d   = '0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (!bus_ready_n_i) begin
                    dataOut_d = bus_data_in_i;
                    busRdN_d  = 1'b1;
                    done_d    = 1'b1;
                    state_d   = RELEASE;
                end else if (TIMEOUT_EN && (timer_q == TIMER_LAST)) begin
                    busRdN_d  = 1'b1;
                    error_d   = 1'b1;
                    done_d    = 1'b1;
                    state_d   = RELEASE;
                end else begin
                    timer_d   = timer_q + 1'b1;
                end
            end
            RELEASE: begin
                if (bus_ready_n_i) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_out_o = dataOut_q;
    assign done_o     = done_q;
    assign busy_o     = busy_q;
    assign error_o    = error_q;
    assign bus_addr_o = busAddr_q;
    assign bus_rd_n_o = busRdN_q;

endmodule

// File: tb/tb_mem_read_port.sv
// Directed testbench for mem_read_port. Two instances share the same inputs:
// dutA uses an 8-cycle timeout and dutB uses a 4-cycle timeout.

module tb_mem_read_port;

    logic        clk;
    logic        reset;
    logic        startN;
    logic [15:0] addrIn;
    logic [15:0] busDataIn;
    logic        busReadyN;

    logic [15:0] dataOutA, busAddrA;
    logic        doneA, busyA, errorA, busRdNA;
    logic [15:0] dataOutB, busAddrB;
    logic        doneB, busyB, errorB, busRdNB;

    int checks = 0;
    int errors = 0;
    int doneCount;

    mem_read_port #(.DATAWIDTH(16), .ADDRWIDTH(16), .TIMEOUT(8), .TWIDTH(8)) dutA (
        .clk_i(clk), .reset_i(reset), .start_n_i(startN), .addr_in_i(addrIn),
        .data_out_o(dataOutA), .done_o(doneA), .busy_o(busyA), .error_o(errorA),
        .bus_addr_o(busAddrA), .bus_rd_n_o(busRdNA),
        .bus_data_in_i(busDataIn), .bus_ready_n_i(busReadyN)
    );

    mem_read_port #(.DATAWIDTH(16), .ADDRWIDTH(16), .TIMEOUT(4), .TWIDTH(8)) dutB (
        .clk_i(clk), .reset_i(reset), .start_n_i(startN), .addr_in_i(addrIn),
        .data_out_o(dataOutB), .done_o(doneB), .busy_o(busyB), .error_o(errorB),
        .bus_addr_o(busAddrB), .bus_rd_n_o(busRdNB),
        .bus_data_in_i(busDataIn), .bus_ready_n_i(busReadyN)
    );

    // Free-running clock; the DUT acts on the falling edge.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Advance past one falling edge; outputs have settled when this returns.
    task automatic applyStimulus();
        @(negedge clk);
        #2;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Directed sequence covering reset, normal read, timeout, held request, race, reset abort, sticky ready.
    initial begin
        reset = 1'b0; startN = 1'b1; addrIn = 16'h0000;
        busDataIn = 16'h0000; busReadyN = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_busy", busyA, 0);
        checkOutput("rst_done", doneA, 0);
        checkOutput("rst_rdn", busRdNA, 1);
        checkOutput("rst_data", dataOutA, 16'h0000);
        checkOutput("rst_error", errorA, 0);
        checkOutput("rst_addr", busAddrA, 16'h0000);
        reset = 1'b1;
        applyStimulus();

        // Test 1: normal read, ready after 3 cycles.
        $display("[TB] test 1: normal read");
        startN = 1'b0; addrIn = 16'h0040;
        applyStimulus();
        checkOutput("t1_acc_rdn", busRdNA, 0);
        checkOutput("t1_acc_busy", busyA, 1);
        checkOutput("t1_acc_addr", busAddrA, 16'h0040);
        startN = 1'b1; addrIn = 16'h1234;
        applyStimulus();
        checkOutput("t1_w1_rdn", busRdNA, 0);
        checkOutput("t1_w1_addr", busAddrA, 16'h0040);
        applyStimulus();
        checkOutput("t1_w2_rdn", busRdNA, 0);
        checkOutput("t1_w2_done", doneA, 0);
        busReadyN = 1'b0; busDataIn = 16'hBEEF;
        applyStimulus();
        checkOutput("t1_done", doneA, 1);
        checkOutput("t1_data", dataOutA, 16'hBEEF);
        checkOutput("t1_error", errorA, 0);
        checkOutput("t1_rdn_rel", busRdNA, 1);
        checkOutput("t1_busy_rel", busyA, 1);
        busReadyN = 1'b1; busDataIn = 16'h0000;
        applyStimulus();
        checkOutput("t1_done_pulse", doneA, 0);
        checkOutput("t1_busy_end", busyA, 0);

        // Test 2: timeout with no responder.
        $display("[TB] test 2: timeout");
        startN = 1'b0; addrIn = 16'h0080;
        applyStimulus();
        startN = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            applyStimulus();
            if (i == 4) begin
                checkOutput("t2_b_done4", doneB, 1);
                checkOutput("t2_b_error4", errorB, 1);
            end
        end
        checkOutput("t2_done7", doneA, 0);
        checkOutput("t2_rdn7", busRdNA, 0);
        applyStimulus();
        checkOutput("t2_done8", doneA, 1);
        checkOutput("t2_error8", errorA, 1);
        checkOutput("t2_rdn8", busRdNA, 1);
        checkOutput("t2_data_kept", dataOutA, 16'hBEEF);
        applyStimulus();
        checkOutput("t2_done_pulse", doneA, 0);
        checkOutput("t2_busy_end", busyA, 0);
        checkOutput("t2_error_held", errorA, 1);

        // Test 3: start_n held low for 20 cycles, instant ready.
        $display("[TB] test 3: held request");
        startN = 1'b0; addrIn = 16'h00C0;
        applyStimulus();
        checkOutput("t3_acc_busy", busyA, 1);
        checkOutput("t3_error_clr", errorA, 0);
        busReadyN = 1'b0; busDataIn = 16'h1111;
        applyStimulus();
        checkOutput("t3_done", doneA, 1);
        checkOutput("t3_data", dataOutA, 16'h1111);
        busReadyN = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 18; i++) begin
            applyStimulus();
            doneCount += int'(doneA);
            if (busRdNA !== 1'b1) doneCount += 100;
        end
        checkOutput("t3_no_reread", doneCount, 0);
        checkOutput("t3_idle", busyA, 0);
        startN = 1'b1;
        applyStimulus();
        startN = 1'b0; addrIn = 16'h00D0;
        applyStimulus();
        checkOutput("t3_second_acc", busRdNA, 0);
        checkOutput("t3_second_addr", busAddrA, 16'h00D0);
        startN = 1'b1; busReadyN = 1'b0; busDataIn = 16'h2222;
        applyStimulus();
        checkOutput("t3_second_done", doneA, 1);
        checkOutput("t3_second_data", dataOutA, 16'h2222);
        busReadyN = 1'b1;
        applyStimulus();

        // Test 4: ready and timeout on the same edge (dutB, TIMEOUT=4).
        $display("[TB] test 4: race");
        startN = 1'b0; addrIn = 16'h0100;
        applyStimulus();
        startN = 1'b1;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("t4_b_wait", doneB, 0);
        busReadyN = 1'b0; busDataIn = 16'h3333;
        applyStimulus();
        checkOutput("t4_b_done", doneB, 1);
        checkOutput("t4_b_error", errorB, 0);
        checkOutput("t4_b_data", dataOutB, 16'h3333);
        busReadyN = 1'b1;
        applyStimulus();
        checkOutput("t4_b_busy_end", busyB, 0);

        // Test 5: reset during WAIT aborts the read.
        $display("[TB] test 5: reset mid-wait");
        startN = 1'b0; addrIn = 16'h0200;
        applyStimulus();
        startN = 1'b1;
        applyStimulus();
        reset = 1'b0;
        applyStimulus();
        checkOutput("t5_rdn", busRdNA, 1);
        checkOutput("t5_data", dataOutA, 16'h0000);
        checkOutput("t5_busy", busyA, 0);
        checkOutput("t5_done", doneA, 0);
        reset = 1'b1;
        applyStimulus();
        checkOutput("t5_no_done", doneA, 0);
        startN = 1'b0; addrIn = 16'h0300;
        applyStimulus();
        checkOutput("t5_clean_addr", busAddrA, 16'h0300);
        startN = 1'b1; busReadyN = 1'b0; busDataIn = 16'h4444;
        applyStimulus();
        checkOutput("t5_clean_done", doneA, 1);
        checkOutput("t5_clean_data", dataOutA, 16'h4444);
        busReadyN = 1'b1;
        applyStimulus();

        // Test 6: ready stuck low after completion; new requests are ignored.
        $display("[TB] test 6: sticky ready");
        startN = 1'b0; addrIn = 16'h0400;
        applyStimulus();
        startN = 1'b1; busReadyN = 1'b0; busDataIn = 16'h5555;
        applyStimulus();
        checkOutput("t6_done", doneA, 1);
        addrIn = 16'h0500;
        for (int i = 0; i < 5; i++) begin
            startN = (i % 2 == 0) ? 1'b0 : 1'b1;
            applyStimulus();
        end
        checkOutput("t6_busy_stuck", busyA, 1);
        checkOutput("t6_rdn_stuck", busRdNA, 1);
        checkOutput("t6_addr_stuck", busAddrA, 16'h0400);
        checkOutput("t6_no_done", doneA, 0);
        startN = 1'b1; busReadyN = 1'b1;
        applyStimulus();
        checkOutput("t6_busy_end", busyA, 0);
        applyStimulus();
        checkOutput("t6_no_new_read", busRdNA, 1);
        checkOutput("t6_data_kept", dataOutA, 16'h5555);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
